// File: rtl/om_pkg.sv
// Shared signed-digit encoding and digit arithmetic helpers for the online multiplier array.
package om_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    // Wide enough for any residual width the array is instantiated with
    localparam int FRAG_W = 32;

    // {p,n} -> p-n; the redundant 11 code decodes to zero
    function automatic logic signed [1:0] dig_val(input logic [1:0] d);
        case (d)
            DIG_POS: return 2'sb01;
            DIG_NEG: return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

    function automatic logic signed [FRAG_W-1:0] dig_sel(input logic [1:0] d,
                                                        input logic signed [FRAG_W-1:0] f);
        case (dig_val(d))
            2'sb01:  return f;
            2'sb11:  return -f;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/om_stage.sv
// One online-multiplier array stage: residual doubling, fragment accumulation,
// digit selection and residual correction.
module om_stage
    import om_pkg::*;
#(
    parameter  int Stage = 8,
    localparam int RW    = Stage + 3
) (
    input  logic signed [RW-1:0]    i_w,
    input  logic [1:0]              i_xd,
    input  logic [1:0]              i_yd,
    input  logic [Stage-1:0]        i_a,
    input  logic [Stage-1:0]        i_b,
    input  logic                    i_cin,
    output logic signed [RW-1:0]    o_w,
    output logic [1:0]              o_z
);

    localparam logic signed [RW-1:0] U    = RW'(2 ** (Stage - 1));
    localparam logic signed [RW-1:0] HALF = RW'(2 ** (Stage - 2));

    logic signed [FRAG_W-1:0] w_ya;
    logic signed [FRAG_W-1:0] w_xb;
    logic signed [FRAG_W-1:0] w_t;
    logic signed [RW-1:0]     w_p;
    logic signed [RW-1:0]     w_zu;
    logic                     w_unused_t;

    assign w_ya = dig_sel(i_yd, {{(FRAG_W-Stage){i_a[Stage-1]}}, i_a});
    assign w_xb = dig_sel(i_xd, {{(FRAG_W-Stage){i_b[Stage-1]}}, i_b});
    assign w_t  = w_ya + w_xb;
    // Residual arithmetic is modulo 2^RW; the upper product bits are sign copies
    assign w_p  = (i_w <<< 1) + w_t[RW-1:0] + RW'(i_cin);
    assign w_unused_t = ^w_t[FRAG_W-1:RW];

    always_comb begin
        o_z  = DIG_ZERO;
        w_zu = '0;
        if (w_p >= HALF) begin
            o_z  = DIG_POS;
            w_zu = U;
        end else if (w_p < -HALF) begin
            o_z  = DIG_NEG;
            w_zu = -U;
        end
        o_w = w_p - w_zu;
    end

endmodule

// File: rtl/om_top_mult.sv
// Fully unrolled radix-2 online signed-digit multiplier: input registers,
// combinational stage chain, registered product digits.
module om_top_mult
    import om_pkg::*;
#(
    parameter  int Stage = 8,
    localparam int WL    = 2 * Stage
) (
    input  logic                      clk,
    input  logic                      nReset,
    input  logic [WL-1:0]             x,
    input  logic [WL-1:2]             y,
    input  logic [Stage*(Stage-1):0]  xY,
    input  logic [Stage*(Stage-1)-1:0] yX,
    output logic [WL-1:0]             z
);

    localparam int RW = Stage + 3;

    logic [WL-1:0]              r_x;
    logic [WL-1:2]              r_y;
    logic [Stage*(Stage-1):0]   r_xY;
    logic [Stage*(Stage-1)-1:0] r_yX;
    logic [WL-1:0]              r_z;

    logic signed [RW-1:0] w_w [0:Stage-1];
    logic signed [RW-1:0] w_unused_res;
    logic [WL-1:0]        w_z;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_x  <= '0;
            r_y  <= '0;
            r_xY <= '0;
            r_yX <= '0;
            r_z  <= '0;
        end else begin
            r_x  <= x;
            r_y  <= y;
            r_xY <= xY;
            r_yX <= yX;
            r_z  <= w_z;
        end
    end

    assign w_w[0] = '0;

    generate
        for (genvar j = 1; j <= Stage; j++) begin : g_stage
            if (j < Stage) begin : g_mid
                om_stage #(.Stage(Stage)) u_stage (
                    .i_w   (w_w[j-1]),
                    .i_xd  (r_x[WL-2*j+1 -: 2]),
                    .i_yd  (r_y[WL-2*j+1 -: 2]),
                    .i_a   (r_xY[Stage*(Stage-j) -: Stage]),
                    .i_b   (r_yX[Stage*(Stage-j)-1 -: Stage]),
                    .i_cin ((j == 1) ? r_xY[0] : 1'b0),
                    .o_w   (w_w[j]),
                    .o_z   (w_z[WL-2*j+1 -: 2])
                );
            end else begin : g_last
                // Last digit of x meets zero fragments, so it never affects the product
                om_stage #(.Stage(Stage)) u_stage (
                    .i_w   (w_w[Stage-1]),
                    .i_xd  (r_x[1:0]),
                    .i_yd  (DIG_ZERO),
                    .i_a   ('0),
                    .i_b   ('0),
                    .i_cin (1'b0),
                    .o_w   (w_unused_res),
                    .o_z   (w_z[1:0])
                );
            end
        end
    endgenerate

    assign z = r_z;

endmodule

// File: tb/tb_om_top_mult.sv
// Self-checking bench for om_top_mult (Stage=8): directed table, reset corner
// sequences and bounded random vectors against an independent recurrence model.
module tb_om_top_mult;

    logic        clk;
    logic        nReset;
    logic [15:0] x;
    logic [15:2] y;
    logic [56:0] xY;
    logic [55:0] yX;
    logic [15:0] z;

    int checks = 0;
    int errors = 0;

    om_top_mult #(.Stage(8)) dut (
        .clk    (clk),
        .nReset (nReset),
        .x      (x),
        .y      (y),
        .xY     (xY),
        .yX     (yX),
        .z      (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [15:0] y;
        logic [56:0] xy;
        logic [55:0] yx;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic [15:0] xv, input logic [15:0] yv,
                       input logic [56:0] xyv, input logic [55:0] yxv, input logic [15:0] e);
        vec_t v;
        v.name = n; v.x = xv; v.y = yv; v.xy = xyv; v.yx = yxv; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [15:0] xv, input logic [15:0] yv,
                         input logic [56:0] xyv, input logic [55:0] yxv);
        x  = xv;
        y  = yv[15:2];
        xY = xyv;
        yX = yxv;
    endtask

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: z=%h expected %h", n, act, e);
        end
    endtask

    function automatic int dv(input logic [1:0] d);
        case (d)
            2'b10:   return 1;
            2'b01:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int wrap11(input int v);
        logic [10:0] b;
        b = v[10:0];
        return int'($signed(b));
    endfunction

    function automatic logic [15:0] ref_z(input logic [15:0] xv, input logic [15:2] yv,
                                          input logic [56:0] xyv, input logic [55:0] yxv);
        int w, p, t, zi;
        logic [7:0]  a, b;
        logic [15:0] r;
        w = 0;
        r = '0;
        for (int j = 1; j <= 8; j++) begin
            t = 0;
            if (j < 8) begin
                a = xyv[8*(8-j) -: 8];
                b = yxv[8*(8-j)-1 -: 8];
                t = dv(yv[17-2*j -: 2]) * int'($signed(a)) + dv(xv[17-2*j -: 2]) * int'($signed(b));
            end
            p = wrap11(2 * w + t + ((j == 1) ? int'(xyv[0]) : 0));
            if (p >= 64)       zi = 1;
            else if (p < -64)  zi = -1;
            else               zi = 0;
            r[17-2*j -: 2] = (zi == 1) ? 2'b10 : (zi == -1) ? 2'b01 : 2'b00;
            w = wrap11(p - zi * 128);
        end
        return r;
    endfunction

    initial begin
        logic [15:0] rx;
        logic [15:0] ry;
        logic [56:0] rxy;
        logic [55:0] ryx;

        add("zero",        16'h0000, 16'h0000, 57'h0,          56'h0,          16'h0000);
        add("y1p_A40",     16'h0000, 16'h8000, 57'h40 << 49,   56'h0,          16'h9000);
        add("y1n_A40",     16'h0000, 16'h4000, 57'h40 << 49,   56'h0,          16'h1000);
        add("y1p_A20",     16'h0000, 16'h8000, 57'h20 << 49,   56'h0,          16'h2400);
        add("x1p_B40",     16'h8000, 16'h0000, 57'h0,          56'h40 << 48,   16'h9000);
        add("x1_11_B40",   16'hC000, 16'h0000, 57'h0,          56'h40 << 48,   16'h0000);
        add("y1_11_A40",   16'h0000, 16'hC000, 57'h40 << 49,   56'h0,          16'h0000);
        add("cin_only",    16'h0000, 16'h0000, 57'h1,          56'h0,          16'h0009);
        add("below_half",  16'h0000, 16'h8000, 57'h3F << 49,   56'h0,          16'h2001);
        add("below_nhalf", 16'h0000, 16'h4000, 57'h41 << 49,   56'h0,          16'h6001);
        add("y2p_A2_40",   16'h0000, 16'h2000, 57'h40 << 41,   56'h0,          16'h2400);
        add("x8_ignored",  16'h0002, 16'h0000, 57'h0,          56'h0,          16'h0000);

        // Reset held with live operands: output must stay cleared
        nReset = 1'b0;
        drive(16'h0000, 16'h8000, 57'h40 << 49, 56'h0);
        #1 check("reset_start", z, 16'h0000);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("reset_held", z, 16'h0000);

        drive(16'h0, 16'h0, 57'h0, 56'h0);
        nReset = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("zero_after_release", z, 16'h0000);

        foreach (vecs[i]) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].xy, vecs[i].yx);
            @(posedge clk); @(posedge clk); @(negedge clk);
            check(vecs[i].name, z, vecs[i].exp);
        end

        // Asynchronous clear in the middle of a held operation
        drive(16'h0000, 16'h8000, 57'h40 << 49, 56'h0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("pre_reset_value", z, 16'h9000);
        #2 nReset = 1'b0;
        #1 check("async_clear", z, 16'h0000);
        drive(16'h0000, 16'h8000, 57'h20 << 49, 56'h0);
        @(posedge clk); @(negedge clk);
        check("clear_through_edge", z, 16'h0000);
        nReset = 1'b1;
        @(posedge clk); #1;
        check("first_edge_after_release", z, 16'h0000);
        @(posedge clk); @(negedge clk);
        check("second_edge_after_release", z, 16'h2400);

        // Operand change seen only after two edges, previous product held in between
        drive(16'h8000, 16'h0000, 57'h0, 56'h40 << 48);
        @(posedge clk); #1;
        check("latency_one_edge", z, 16'h2400);
        @(posedge clk); #1;
        check("latency_two_edges", z, 16'h9000);

        // Bounded fragments keep |W| <= U/2 so the model needs no overflow handling
        for (int n = 0; n < 9000; n++) begin
            @(negedge clk);
            rx  = 16'($urandom);
            ry  = 16'($urandom) & 16'hFFFC;
            rxy = '0;
            ryx = '0;
            for (int j = 1; j < 8; j++) begin
                rxy[8*(8-j) -: 8]   = 8'($urandom_range(0, 63)) - 8'd32;
                ryx[8*(8-j)-1 -: 8] = 8'($urandom_range(0, 63)) - 8'd32;
            end
            rxy[0] = 1'($urandom);
            drive(rx, ry, rxy, ryx);
            @(posedge clk); @(posedge clk); @(negedge clk);
            check("rand", z, ref_z(rx, ry[15:2], rxy, ryx));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/om_top_mult.md
Name: om_top_mult

Overview:
- Fully unrolled radix-2 online (MSB-first) signed-digit multiplier array.
- Inputs:
  - two signed-digit operands, x and y;
  - precomputed two's-complement partial-product fragments, xY and yX.
- Output: a Stage-digit signed-digit product z, registered.
- Used as the combinational-core-plus-register block of the online-arithmetic datapath.
- The operand pair is held for 2 clocks and then cleared by a reset pulse.

Parameters:
- Stage, default 8: number of product digits and array stages.
- WL, default 2*Stage: bit width of a signed-digit word (2 bits per digit). Derived; do not override.
- U, internal, 2^(Stage-1): residual integer weight of 1.0.

Ports:
- clk: input, 1 bit. Single clock.
- nReset: input, 1 bit. Reset is asynchronous and active-low.
- x: input, WL bits [WL-1:0]. Signed-digit operand; digit i (i=1..Stage, MSD first) at bits [WL-2i+1:WL-2i].
- y: input, WL-2 bits [WL-1:2]. Signed-digit operand, digits 1..Stage-1, same placement.
- xY: input, Stage*(Stage-1)+1 bits. Fragments A_j plus carry-in.
- yX: input, Stage*(Stage-1) bits. Fragments B_j.
- z: output, WL bits [WL-1:0]. Signed-digit product, same digit placement as x.

Behaviour:
- Digit encoding is {p,n}, with value p-n:
  - 10 = +1
  - 01 = -1
  - 00 = 0
  - 11 = 0 on input; never produced on output.
- Fragment placement (j=1..Stage-1):
  - A_j = xY[Stage*(Stage-j) : Stage*(Stage-j-1)+1], a Stage-bit two's complement integer.
  - cin = xY[0].
  - B_j = yX[Stage*(Stage-j)-1 : Stage*(Stage-j-1)], a Stage-bit two's complement integer.
  - Chunk j=1 is the most significant chunk.
- Residual arithmetic uses a signed integer of Stage+3 bits; W_0 = 0.
- For each j=1..Stage-1:
  - T_j = y_j*A_j + x_j*B_j, where digit multiply is select / negate / zero, with sign extension.
  - P_j = 2*W_{j-1} + T_j, plus cin when j=1.
- For j=Stage: P_Stage = 2*W_{Stage-1}. x digit Stage does not enter the datapath.
- Digit selection:
  - z_j = +1 if P_j >= U/2.
  - z_j = -1 if P_j < -U/2.
  - z_j = 0 otherwise.
- Residual update: W_j = P_j - z_j*U.
- Timing:
  - All inputs are captured in input registers on a clk rising edge.
  - The array is combinational from the input registers.
  - z is registered on the following edge.
  - Latency is 2 rising edges from input change to valid z.
  - z stays constant while inputs are held stable.
- Reset:
  - nReset=0 asynchronously clears all registers; z=0 immediately and throughout reset.
  - Reset mid-computation discards the operation.
  - After release, the next 2 edges produce the result of the then-present inputs.
- No handshake. The environment holds operands at least 2 cycles.
- Residual overflow is not possible for consistent fragments (|W_j| <= U/2). Inconsistent fragments wrap modulo 2^(Stage+3) without error indication.

Decomposition:
- Package om_pkg holds:
  - digit-encoding constants: DIG_POS=2'b10, DIG_NEG=2'b01, DIG_ZERO=2'b00;
  - a function for digit-times-fragment select/negate;
  - a digit-decode function.
- One sub-module, om_stage, instantiated Stage times via generate:
  - inputs: W_in, digit pair, A, B, cin;
  - outputs: W_out and z digit.
  - The final stage ties A=B=0.
- om_top_mult holds the input and output registers.

Test Plan (Stage=8, U=128, WL=16):
- All inputs zero, nReset released -> z=16'h0000 after 2 edges; z=0 during reset.
- y digit1=+1 (y[15:14]=10), A_1=8'h40, all else 0 -> P1=64, z=10_01_00... = 16'h9000.
- y digit1=-1 (01), A_1=8'h40 -> T1=-64, z1=0, z2=-1 -> z=16'h1000.
- y digit1=+1, A_1=8'h20 -> z1=0, z2=+1, z3=-1 -> z=16'h2400.
- x digit1=+1 (x[15:14]=10), B_1=8'h40, y=0 -> z=16'h9000.
  - Then x digit1 encoded 11 -> z=16'h0000.
- Hold case-2 inputs for 2 clocks, assert nReset=0 mid-cycle -> z=0 asynchronously.
  - Release with case-4 inputs -> z=16'h2400 after 2 edges.
  - Repeat 9000 random consistent vectors against the reference recurrence.
